// File: rtl/eth_pkg.sv
// Shared Rx AXIS definitions: bus widths, FIFO entry layout and write FSM states.
package eth_pkg;

   localparam int AXIS_DATA_W = 32;
   localparam int AXIS_KEEP_W = 4;

   // One buffered beat; tlast travels with the data so frame boundaries survive the RAM.
   typedef struct packed {
      logic                   tlast;
      logic [AXIS_KEEP_W-1:0] tkeep;
      logic [AXIS_DATA_W-1:0] tdata;
   } fifo_entry_t;

   localparam int ENTRY_W = $bits(fifo_entry_t);

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_WRITE = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register only updates on re_i, so it doubles as a holding stage.
module sdp_ram #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 512
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Array write and enabled synchronous read; no reset on the storage.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_frame_fifo.sv
// Store-and-forward Rx frame FIFO. Frames are written speculatively and only
// become visible to the reader once their last beat arrives clean; errored or
// overflowing frames are rewound away. Read side is RAM register + output
// register, which keeps one beat per cycle under tready=1 and holds under stall.
module rx_frame_fifo
   import eth_pkg::*;
#(
   parameter int DEPTH   = 512,
   parameter int COUNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [AXIS_DATA_W-1:0] s00_axis_tdata,
   input  logic [AXIS_KEEP_W-1:0] s00_axis_tkeep,
   input  logic                   s00_axis_tvalid,
   input  logic                   s00_axis_tlast,
   input  logic                   s00_axis_tuser,
   output logic [AXIS_DATA_W-1:0] m00_axis_tdata,
   output logic [AXIS_KEEP_W-1:0] m00_axis_tkeep,
   output logic                   m00_axis_tvalid,
   output logic                   m00_axis_tlast,
   input  logic                   m00_axis_tready,
   output logic [COUNT_W-1:0]     o_frame_count,
   output logic [COUNT_W-1:0]     o_err_drop_count,
   output logic [COUNT_W-1:0]     o_ovf_drop_count
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0]   DEPTH_P = PTR_W'(DEPTH);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   wr_state_t        state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             full, empty, wr_en;
   logic             frame_inc, err_inc, ovf_inc;

   logic             rd_en, out_ready;
   logic             rd_vld_q, rd_vld_d;
   logic             m_valid_q, m_valid_d;
   fifo_entry_t      m_data_q, m_data_d;
   fifo_entry_t      wr_entry, rd_entry;

   logic [COUNT_W-1:0] frame_cnt_q, err_cnt_q, ovf_cnt_q;

   // Full uses the pre-read rd_ptr, so a same-cycle read never frees room early.
   assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
   assign empty = (rd_ptr_q == commit_ptr_q);

   assign wr_entry = '{tlast: s00_axis_tlast, tkeep: s00_axis_tkeep, tdata: s00_axis_tdata};

   // Write FSM: speculative write, commit on clean tlast, rewind on error/overflow.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wr_en        = 1'b0;
      frame_inc    = 1'b0;
      err_inc      = 1'b0;
      ovf_inc      = 1'b0;
      if (s00_axis_tvalid) begin
         case (state_q)
            WR_IDLE, WR_WRITE: begin
               if (!full) begin
                  wr_en = 1'b1;
                  if (s00_axis_tlast) begin
                     state_d = WR_IDLE;
                     if (s00_axis_tuser) begin
                        wr_ptr_d = commit_ptr_q;
                        err_inc  = 1'b1;
                     end else begin
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        commit_ptr_d = wr_ptr_q + 1'b1;
                        frame_inc    = 1'b1;
                     end
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                     state_d  = WR_WRITE;
                  end
               end else begin
                  // In IDLE wr_ptr already equals commit_ptr, so the rewind is a no-op there.
                  wr_ptr_d = commit_ptr_q;
                  if (s00_axis_tlast) begin
                     ovf_inc = 1'b1;
                     state_d = WR_IDLE;
                  end else begin
                     state_d = WR_DROP;
                  end
               end
            end
            WR_DROP: begin
               if (s00_axis_tlast) begin
                  ovf_inc = 1'b1;
                  state_d = WR_IDLE;
               end
            end
            default: state_d = WR_IDLE;
         endcase
      end
   end

   // Read side: fetch a committed word whenever the RAM register is free or draining.
   always_comb begin
      out_ready = !m_valid_q || m00_axis_tready;
      rd_en     = !empty && (!rd_vld_q || out_ready);
      rd_ptr_d  = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_vld_d  = rd_en ? 1'b1 : (out_ready ? 1'b0 : rd_vld_q);
      m_valid_d = out_ready ? rd_vld_q : m_valid_q;
      m_data_d  = (out_ready && rd_vld_q) ? rd_entry : m_data_q;
   end

   // Pointer, FSM and output-stage state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= WR_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         rd_vld_q     <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_vld_q     <= rd_vld_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
         ovf_cnt_q   <= '0;
      end else begin
         if (frame_inc && frame_cnt_q != CNT_MAX) frame_cnt_q <= frame_cnt_q + 1'b1;
         if (err_inc   && err_cnt_q   != CNT_MAX) err_cnt_q   <= err_cnt_q + 1'b1;
         if (ovf_inc   && ovf_cnt_q   != CNT_MAX) ovf_cnt_q   <= ovf_cnt_q + 1'b1;
      end
   end

   sdp_ram #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (i_clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (wr_entry),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (rd_entry)
   );

   assign m00_axis_tvalid  = m_valid_q;
   assign m00_axis_tdata   = m_data_q.tdata;
   assign m00_axis_tkeep   = m_data_q.tkeep;
   assign m00_axis_tlast   = m_data_q.tlast;
   assign o_frame_count    = frame_cnt_q;
   assign o_err_drop_count = err_cnt_q;
   assign o_ovf_drop_count = ovf_cnt_q;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: a DEPTH=512 instance and a DEPTH=16/COUNT_W=4
// instance share the stimulus; a scoreboard holds expected good-frame beats.
module tb_rx_frame_fifo;
   import eth_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] s_tdata;
   logic [3:0]  s_tkeep;
   logic        s_tvalid, s_tlast, s_tuser;
   logic        tready;

   logic [31:0] a_tdata, b_tdata;
   logic [3:0]  a_tkeep, b_tkeep;
   logic        a_tvalid, a_tlast, b_tvalid, b_tlast;
   logic [15:0] a_frm, a_err, a_ovf;
   logic [3:0]  b_frm, b_err, b_ovf;

   rx_frame_fifo #(.DEPTH(512), .COUNT_W(16)) dut_a (
      .i_clk(clk), .i_reset(rst),
      .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
      .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
      .m00_axis_tdata(a_tdata), .m00_axis_tkeep(a_tkeep), .m00_axis_tvalid(a_tvalid),
      .m00_axis_tlast(a_tlast), .m00_axis_tready(tready),
      .o_frame_count(a_frm), .o_err_drop_count(a_err), .o_ovf_drop_count(a_ovf));

   rx_frame_fifo #(.DEPTH(16), .COUNT_W(4)) dut_b (
      .i_clk(clk), .i_reset(rst),
      .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
      .s00_axis_tlast(s_tlast), .s00_axis_tuser(s_tuser),
      .m00_axis_tdata(b_tdata), .m00_axis_tkeep(b_tkeep), .m00_axis_tvalid(b_tvalid),
      .m00_axis_tlast(b_tlast), .m00_axis_tready(tready),
      .o_frame_count(b_frm), .o_err_drop_count(b_err), .o_ovf_drop_count(b_ovf));

   bit use16;
   logic        m_tvalid, m_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   assign m_tvalid = use16 ? b_tvalid : a_tvalid;
   assign m_tlast  = use16 ? b_tlast  : a_tlast;
   assign m_tdata  = use16 ? b_tdata  : a_tdata;
   assign m_tkeep  = use16 ? b_tkeep  : a_tkeep;

   int          checks = 0;
   int          errors = 0;
   fifo_entry_t sb[$];
   int          rx_cnt = 0;
   int          cyc = 0;
   int          first_vld_cyc = -1;
   int          last_commit_cyc = 0;
   bit          toggle_en = 0;

   function automatic int sat15(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_en) tready = ~tready;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic last, input logic user);
      s_tdata = d; s_tkeep = k; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
   endtask

   // Sends a frame; good frames have their beats queued on the scoreboard first.
   task automatic send_frame(input int len, input logic user, input bit push);
      fifo_entry_t e;
      for (int i = 0; i < len; i++) begin
         e.tdata = $urandom;
         e.tlast = (i == len - 1);
         e.tkeep = e.tlast ? 4'($urandom_range(1, 15)) : 4'hF;
         if (push) sb.push_back(e);
         send_beat(e.tdata, e.tkeep, e.tlast, e.tlast ? user : 1'($urandom_range(0, 1)));
      end
      last_commit_cyc = cyc;
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      tick(); tick();
      rst = 1'b0;
      sb.delete();
      tick();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin tick(); n++; end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout left=%0d required=0", sb.size());
      end
      repeat (6) tick();
   endtask

   // Output checker: every handshake is compared against the scoreboard head,
   // and a stalled beat must stay valid and unchanged.
   task automatic monitor();
      fifo_entry_t act, prev, exp;
      bit stall = 0;
      forever begin
         @(negedge clk);
         act = '{tlast: m_tlast, tkeep: m_tkeep, tdata: m_tdata};
         if (rst) begin
            stall = 0;
         end else begin
            if (stall) begin
               checks++;
               if (m_tvalid !== 1'b1 || act !== prev) begin
                  errors++;
                  $display("FAIL stall_hold valid=%b data=%h required valid=1 data=%h", m_tvalid, act, prev);
               end
            end
            if (first_vld_cyc < 0 && m_tvalid === 1'b1) first_vld_cyc = cyc;
            if (m_tvalid === 1'b1 && tready === 1'b1) begin
               rx_cnt++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat got=%h required=none", act);
               end else begin
                  exp = sb.pop_front();
                  if (act !== exp) begin
                     errors++;
                     $display("FAIL beat_data got=%h required=%h", act, exp);
                  end
               end
            end
            stall = (m_tvalid === 1'b1) && (tready !== 1'b1);
            prev  = act;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      s_tdata = '0; s_tkeep = '0; tready = 1'b0;
      #3;
      checks++;
      if ({a_tvalid, a_tlast, a_tdata, a_tkeep} !== 38'd0) begin
         errors++; $display("FAIL reset_out_a got=%h required=0", {a_tvalid, a_tlast, a_tdata, a_tkeep});
      end
      checks++;
      if ({b_tvalid, b_tlast, b_tdata, b_tkeep} !== 38'd0) begin
         errors++; $display("FAIL reset_out_b got=%h required=0", {b_tvalid, b_tlast, b_tdata, b_tkeep});
      end
      checks++;
      if ({a_frm, a_err, a_ovf, b_frm, b_err, b_ovf} !== 60'd0) begin
         errors++; $display("FAIL reset_counters got=%h required=0", {a_frm, a_err, a_ovf, b_frm, b_err, b_ovf});
      end
      do_reset();
   endtask

   task automatic test_back_to_back();
      int rx0, c1;
      use16 = 0; do_reset(); tready = 1'b1;
      rx0 = rx_cnt; first_vld_cyc = -1;
      send_frame(16, 1'b0, 1);
      c1 = last_commit_cyc;
      send_frame(16, 1'b0, 1);
      send_frame(16, 1'b0, 1);
      wait_drain(500);
      checks++;
      if (rx_cnt - rx0 != 48) begin errors++; $display("FAIL b2b_beats got=%0d required=48", rx_cnt - rx0); end
      checks++;
      if (a_frm !== 16'd3) begin errors++; $display("FAIL b2b_frame_count got=%0d required=3", a_frm); end
      checks++;
      if (first_vld_cyc - c1 != 2) begin
         errors++; $display("FAIL b2b_latency got=%0d required=2", first_vld_cyc - c1);
      end
   endtask

   task automatic test_err_frame();
      int rx0;
      use16 = 0; do_reset(); tready = 1'b1; rx0 = rx_cnt;
      send_frame(8, 1'b0, 1);
      send_frame(10, 1'b1, 0);
      send_frame(4, 1'b0, 1);
      wait_drain(500);
      checks++;
      if (rx_cnt - rx0 != 12) begin errors++; $display("FAIL err_beats got=%0d required=12", rx_cnt - rx0); end
      checks++;
      if (a_err !== 16'd1) begin errors++; $display("FAIL err_drop_count got=%0d required=1", a_err); end
      checks++;
      if (a_frm !== 16'd2) begin errors++; $display("FAIL err_frame_count got=%0d required=2", a_frm); end
   endtask

   task automatic test_overflow();
      int rx0;
      use16 = 1; do_reset(); tready = 1'b0; rx0 = rx_cnt;
      send_frame(12, 1'b0, 1);
      send_frame(10, 1'b0, 0);
      repeat (4) tick();
      checks++;
      if (b_ovf !== 4'd1) begin errors++; $display("FAIL ovf_drop_count got=%0d required=1", b_ovf); end
      checks++;
      if (b_frm !== 4'd1) begin errors++; $display("FAIL ovf_frame_count got=%0d required=1", b_frm); end
      checks++;
      if (b_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_stalled_valid got=%b required=1", b_tvalid); end
      tready = 1'b1;
      wait_drain(200);
      checks++;
      if (rx_cnt - rx0 != 12) begin errors++; $display("FAIL ovf_beats got=%0d required=12", rx_cnt - rx0); end
   endtask

   // Frames are only sent once the bench's own bound on buffered words shows
   // they fit, so good/overflow outcome is known without modelling read timing.
   task automatic test_wrap();
      int rx0, sent_good, e_frm, e_err, e_ovf, len, n;
      bit bad;
      use16 = 1; do_reset(); tready = 1'b1; toggle_en = 1;
      rx0 = rx_cnt; sent_good = 0; e_frm = 0; e_err = 0; e_ovf = 0;
      for (int f = 0; f < 1000; f++) begin
         len = $urandom_range(1, 20);
         bad = ($urandom_range(0, 7) == 0);
         if (len <= 16) begin
            n = 0;
            while ((sent_good - (rx_cnt - rx0)) + len > 16 && n < 200) begin tick(); n++; end
            if (n >= 200) begin
               checks++; errors++;
               $display("FAIL wrap_room_timeout frame=%0d", f);
               break;
            end
            if (bad) e_err++;
            else begin e_frm++; sent_good += len; end
            send_frame(len, bad, !bad);
         end else begin
            e_ovf++;
            send_frame(len, bad, 0);
         end
         if ($urandom_range(0, 3) == 0) tick();
      end
      wait_drain(400);
      toggle_en = 0; tready = 1'b1;
      checks++;
      if (rx_cnt - rx0 != sent_good) begin
         errors++; $display("FAIL wrap_beats got=%0d required=%0d", rx_cnt - rx0, sent_good);
      end
      checks++;
      if (b_frm !== 4'(sat15(e_frm))) begin errors++; $display("FAIL wrap_frame_count got=%0d required=%0d", b_frm, sat15(e_frm)); end
      checks++;
      if (b_err !== 4'(sat15(e_err))) begin errors++; $display("FAIL wrap_err_count got=%0d required=%0d", b_err, sat15(e_err)); end
      checks++;
      if (b_ovf !== 4'(sat15(e_ovf))) begin errors++; $display("FAIL wrap_ovf_count got=%0d required=%0d", b_ovf, sat15(e_ovf)); end
   endtask

   task automatic test_reset_mid();
      int rx0;
      use16 = 0; do_reset(); tready = 1'b0;
      send_frame(6, 1'b0, 0);
      send_frame(6, 1'b0, 0);
      for (int i = 0; i < 3; i++) send_beat($urandom, 4'hF, 1'b0, 1'b0);
      rst = 1'b1;
      #2;
      checks++;
      if ({a_tvalid, a_tlast, a_tdata, a_tkeep} !== 38'd0) begin
         errors++; $display("FAIL midrst_out got=%h required=0", {a_tvalid, a_tlast, a_tdata, a_tkeep});
      end
      checks++;
      if ({a_frm, a_err, a_ovf} !== 48'd0) begin
         errors++; $display("FAIL midrst_counters got=%h required=0", {a_frm, a_err, a_ovf});
      end
      tick();
      rst = 1'b0;
      tick();
      tready = 1'b1; rx0 = rx_cnt;
      send_frame(5, 1'b0, 1);
      wait_drain(200);
      checks++;
      if (rx_cnt - rx0 != 5) begin errors++; $display("FAIL midrst_beats got=%0d required=5", rx_cnt - rx0); end
      checks++;
      if (a_frm !== 16'd1) begin errors++; $display("FAIL midrst_frame_count got=%0d required=1", a_frm); end
   endtask

   task automatic test_saturation();
      use16 = 1; do_reset(); tready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send_beat($urandom, 4'hF, 1'b1, 1'b1);
         if (i == 14) begin
            checks++;
            if (b_err !== 4'd15) begin errors++; $display("FAIL sat_at_15 got=%0d required=15", b_err); end
         end
      end
      tick();
      checks++;
      if (b_err !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d required=15", b_err); end
      checks++;
      if (b_frm !== 4'd0) begin errors++; $display("FAIL sat_frame_count got=%0d required=0", b_frm); end
   endtask

   initial begin
      fork
         monitor();
         forever begin @(posedge clk); cyc++; end
         begin
            #2ms;
            $display("FAIL watchdog simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none
      test_reset();
      test_back_to_back();
      test_err_frame();
      test_overflow();
      test_wrap();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
